// File: rtl/decoder_in_debounce_if.sv
// Code delivery bundle between the input debouncer and the decoder core.
// The master side produces codes and status; the slave side returns ready.
interface decoder_in_debounce_if #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] code_o;
  logic             code_valid_o;
  logic             code_ready_i;
  logic             busy_o;
  logic             overrun_o;
  logic [CNT_W-1:0] drop_count_o;

  modport master (
    output code_o,
    output code_valid_o,
    input  code_ready_i,
    output busy_o,
    output overrun_o,
    output drop_count_o
  );

  modport slave (
    input  code_o,
    input  code_valid_o,
    output code_ready_i,
    input  busy_o,
    input  overrun_o,
    input  drop_count_o
  );
endinterface

// File: rtl/decoder_in_debounce.sv
// Two-flop synchronizer, hold-time debouncer and single-entry code buffer
// feeding the decoder; overwritten pending codes are flagged and counted.
module decoder_in_debounce #(
  parameter int WIDTH         = 7,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [WIDTH-1:0]      io_in,
  decoder_in_debounce_if.master dec
);

  localparam logic [7:0]       STABLE   = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             have_last_q, have_last_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             commit;
  logic             deliver;

  always_comb begin
    s1_d        = io_in;
    s2_d        = s1_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    have_last_d = have_last_q;
    last_d      = last_q;
    code_d      = code_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    drop_d      = drop_q;

    commit  = (cnt_q == STABLE) && (s2_q == cand_q) && !done_q;
    // A glitch that settles back on the last delivered code commits silently.
    deliver = commit && (!have_last_q || (cand_q != last_q));

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = 8'd1;
      done_d = 1'b0;
    end else begin
      if (cnt_q < STABLE) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (commit) begin
        done_d = 1'b1;
      end
    end

    if (deliver) begin
      last_d      = cand_q;
      have_last_d = 1'b1;
      code_d      = cand_q;
      valid_d     = 1'b1;
      // Latest code wins; the displaced one is only accounted for.
      if (valid_q && !dec.code_ready_i) begin
        overrun_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + DROP_ONE;
        end
      end
    end else if (valid_q && dec.code_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_q        <= '0;
      s2_q        <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  assign dec.code_o       = code_q;
  assign dec.code_valid_o = valid_q;
  assign dec.busy_o       = (cnt_q < STABLE);
  assign dec.overrun_o    = overrun_q;
  assign dec.drop_count_o = drop_q;

endmodule

// File: tb/tb_decoder_in_debounce.sv
// Directed bench: default instance (S=4) for latency/handshake/overrun/reset,
// second instance (S=1) for short latency and drop counter saturation.
module tb_decoder_in_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] io0;
  logic [6:0] io1;
  int         total = 0;
  int         bad   = 0;
  logic       tog;

  always #5 clk = ~clk;

  decoder_in_debounce_if #(.WIDTH(7), .CNT_W(8)) dif0 ();
  decoder_in_debounce_if #(.WIDTH(7), .CNT_W(8)) dif1 ();

  decoder_in_debounce #(.WIDTH(7), .STABLE_CYCLES(4), .CNT_W(8)) u0 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io0),
    .dec      (dif0)
  );

  decoder_in_debounce #(.WIDTH(7), .STABLE_CYCLES(1), .CNT_W(8)) u1 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io1),
    .dec      (dif1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_code"},    32'(dif0.code_o),       32'h0);
    chk({tag, "_valid"},   32'(dif0.code_valid_o), 32'h0);
    chk({tag, "_overrun"}, 32'(dif0.overrun_o),    32'h0);
    chk({tag, "_drop"},    32'(dif0.drop_count_o), 32'h0);
    chk({tag, "_busy"},    32'(dif0.busy_o),       32'h1);
  endtask

  // Feed one new value to the S=1 instance with ready low, holding 3 edges.
  task automatic feed1(input int n);
    for (int i = 0; i < n; i++) begin
      tog = ~tog;
      io1 = tog ? 7'h0B : 7'h0A;
      repeat (3) tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    io0 = 7'h00;
    io1 = 7'h00;
    tog = 1'b1;
    dif0.code_ready_i = 1'b0;
    dif1.code_ready_i = 1'b1;
    tick();
    tick();
    chk_reset0("reset");

    // Latency: sampled at edge k, commit at edge k+6.
    rst = 1'b0;
    io0 = 7'h79;
    dif0.code_ready_i = 1'b1;
    repeat (5) tick();
    chk("lat_busy_e4", 32'(dif0.busy_o), 32'h1);
    chk("lat_valid_e4", 32'(dif0.code_valid_o), 32'h0);
    tick();
    chk("lat_busy_e5", 32'(dif0.busy_o), 32'h0);
    chk("lat_valid_e5", 32'(dif0.code_valid_o), 32'h0);
    tick();
    chk("lat_valid_e6", 32'(dif0.code_valid_o), 32'h1);
    chk("lat_code_e6", 32'(dif0.code_o), 32'h79);
    tick();
    chk("lat_valid_e7", 32'(dif0.code_valid_o), 32'h0);
    chk("lat_code_hold", 32'(dif0.code_o), 32'h79);

    // Two-cycle glitch to 00 then back to the delivered 79: no new code.
    io0 = 7'h00;
    tick();
    tick();
    io0 = 7'h79;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_valid", 32'(dif0.code_valid_o), 32'h0);
    end
    chk("glitch_drop", 32'(dif0.drop_count_o), 32'h0);
    chk("glitch_busy", 32'(dif0.busy_o), 32'h0);

    // Overrun: 01 then 02 with ready low.
    dif0.code_ready_i = 1'b0;
    io0 = 7'h01;
    repeat (8) tick();
    chk("ovr_valid1", 32'(dif0.code_valid_o), 32'h1);
    chk("ovr_code1", 32'(dif0.code_o), 32'h01);
    chk("ovr_flag0", 32'(dif0.overrun_o), 32'h0);
    io0 = 7'h02;
    repeat (8) tick();
    chk("ovr_code2", 32'(dif0.code_o), 32'h02);
    chk("ovr_valid2", 32'(dif0.code_valid_o), 32'h1);
    chk("ovr_flag", 32'(dif0.overrun_o), 32'h1);
    chk("ovr_drop", 32'(dif0.drop_count_o), 32'h1);
    dif0.code_ready_i = 1'b1;
    tick();
    chk("ovr_accept", 32'(dif0.code_valid_o), 32'h0);
    chk("ovr_code_kept", 32'(dif0.code_o), 32'h02);
    tick();
    chk("ovr_once", 32'(dif0.code_valid_o), 32'h0);

    // Ready on the exact commit edge of a new code.
    dif0.code_ready_i = 1'b0;
    io0 = 7'h03;
    repeat (8) tick();
    chk("sim_valid3", 32'(dif0.code_valid_o), 32'h1);
    chk("sim_code3", 32'(dif0.code_o), 32'h03);
    io0 = 7'h04;
    repeat (6) tick();
    chk("sim_pre_code", 32'(dif0.code_o), 32'h03);
    dif0.code_ready_i = 1'b1;
    tick();
    chk("sim_valid", 32'(dif0.code_valid_o), 32'h1);
    chk("sim_code4", 32'(dif0.code_o), 32'h04);
    chk("sim_drop", 32'(dif0.drop_count_o), 32'h1);
    dif0.code_ready_i = 1'b0;
    tick();
    chk("sim_valid_hold", 32'(dif0.code_valid_o), 32'h1);
    chk("sim_code_hold", 32'(dif0.code_o), 32'h04);

    // Reset while a code is pending, then re-delivery of the same input.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset0("mid_reset");
    repeat (6) tick();
    chk("redeliver_e5", 32'(dif0.code_valid_o), 32'h0);
    tick();
    chk("redeliver_valid", 32'(dif0.code_valid_o), 32'h1);
    chk("redeliver_code", 32'(dif0.code_o), 32'h04);

    // S=1 instance: commit 3 edges after sampling.
    repeat (4) tick();
    io1 = 7'h55;
    repeat (3) tick();
    chk("s1_valid_e2", 32'(dif1.code_valid_o), 32'h0);
    tick();
    chk("s1_valid_e3", 32'(dif1.code_valid_o), 32'h1);
    chk("s1_code", 32'(dif1.code_o), 32'h55);
    tick();
    chk("s1_accept", 32'(dif1.code_valid_o), 32'h0);

    // Drop counter saturation on the S=1 instance.
    dif1.code_ready_i = 1'b0;
    feed1(3);
    chk("sat_drop2", 32'(dif1.drop_count_o), 32'h02);
    chk("sat_overrun", 32'(dif1.overrun_o), 32'h1);
    feed1(252);
    chk("sat_drop254", 32'(dif1.drop_count_o), 32'hFE);
    feed1(1);
    chk("sat_drop255", 32'(dif1.drop_count_o), 32'hFF);
    feed1(2);
    chk("sat_hold", 32'(dif1.drop_count_o), 32'hFF);
    chk("sat_code", 32'(dif1.code_o), 32'(io1));
    chk("sat_valid", 32'(dif1.code_valid_o), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_in_debounce.md
# decoder_in_debounce

Input-conditioning stage directly upstream of the decoder project core. Samples the raw 7-bit `io_in` pad bus, synchronizes it into the clock domain, and debounces it by requiring a value to hold for a programmable number of cycles. Each newly stable code that differs from the last one delivered is presented to the decoder through a single-entry valid/ready buffer. Buffer overruns are counted.

## Interface
- `WIDTH`, 7: width of the pad bus and of the code word.
- `STABLE_CYCLES`, 4: consecutive stable cycles a value must hold before commit; legal range 1..255.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `wb_clk_i`  in  1  single clock; all state updates on its rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `io_in`  in  WIDTH  raw asynchronous pad inputs.
- `code_o`  out  WIDTH  committed code presented to the decoder.
- `code_valid_o`  out  1  `code_o` holds an undelivered code.
- `code_ready_i`  in  1  decoder accepts `code_o` this cycle.
- `busy_o`  out  1  current candidate still settling.
- `overrun_o`  out  1  sticky; a pending code was overwritten.
- `drop_count_o`  out  CNT_W  saturating count of overwritten codes.

## Operation
- Synchronizer: `s1 <= io_in`, `s2 <= s1`. Only `s2` is used downstream.
- Candidate tracking, evaluated every edge:
  - If `s2 != cand`: `cand <= s2`, `cnt <= 1`.
  - Else, if `cnt < STABLE_CYCLES`: `cnt <= cnt + 1`.
  - Else: `cnt` holds at `STABLE_CYCLES`.
- Commit: fires on the first edge where `cnt == STABLE_CYCLES`, `s2 == cand`, and `done == 0`. It sets `done <= 1`; `done` clears whenever `cand` reloads.
  - If `have_last == 0` or `cand != last`: set `last <= cand` and `have_last <= 1`, then deliver `cand` to the output buffer.
  - Otherwise (a glitch returned to the last delivered value): mark done and emit nothing.
- Output buffer, one entry:
  - On delivery with the buffer empty, or with `code_ready_i` high in the same cycle: load `code_o` and set `code_valid_o`.
  - On delivery while `code_valid_o` is high and `code_ready_i` is low: overwrite `code_o` (latest wins), set `overrun_o`, and increment `drop_count_o`. The counter saturates at all-ones.
  - Handshake with no new delivery: when `code_valid_o && code_ready_i`, clear `code_valid_o` next cycle.
  - `code_o` holds its last value after acceptance.
- `busy_o = (cnt < STABLE_CYCLES)`. This is combinational from registered state.
- Reset (`wb_rst_i` high at an edge) applies regardless of any operation in progress:
  - Clears `s1`, `s2`, `cand`, `cnt`, `done`, `have_last`, `last`, `code_o`, `code_valid_o`, `overrun_o`, `drop_count_o`.
  - A pending undelivered code is discarded.
  - After reset, `cnt = 0`, so `busy_o = 1` until the first commit.

## Timing
- Reset values: `code_o = 0`, `code_valid_o = 0`, `overrun_o = 0`, `drop_count_o = 0`, `busy_o = 1`.
- Pipeline for a new value V first sampled into `s1` at edge k:
  - `s2 = V` after edge k+1.
  - `cand = V`, `cnt = 1` after edge k+2.
  - `cnt = STABLE_CYCLES` after edge k+1+S.
  - Commit at edge k+2+S; `code_valid_o` is high from that edge.
- Latency: S+2 edges, i.e. 6 for the default S=4.
- If `io_in` changes before commit, `cand` reloads and the count restarts. No output is produced for the abandoned value.
- `code_valid_o` never depends combinationally on `code_ready_i`.
- Ready asserted while valid is low has no effect.
- Simultaneous accept and delivery: the old code is consumed and the new code is loaded at the same edge. `code_valid_o` stays high, and no drop is counted.

## Test plan
- Reset, then hold `io_in = 7'b1111001` with `code_ready_i = 1`.
  - Required: `code_valid_o` rises exactly 6 edges after the first sampling edge with `code_o = 7'b1111001`.
  - Required: it drops one cycle later, and `busy_o` falls when `cnt` reaches 4.
- Stable 7'h79 delivered, then `io_in = 7'h00` for 2 cycles, then back to 7'h79 indefinitely.
  - Required: no new `code_valid_o` pulse, and `drop_count_o = 0`.
- `code_ready_i = 0`; deliver 7'h01, then a stable 7'h02.
  - Required: `code_o = 7'h02`, `overrun_o = 1`, `drop_count_o = 1`.
  - Then raise ready: 7'h02 is accepted once.
- Ready asserted on the exact edge a new code commits.
  - Required: the old code is accepted, `code_valid_o` stays high with the new code, and the drop count is unchanged.
- Assert `wb_rst_i` for one cycle while `code_valid_o = 1` with ready low.
  - Required: all outputs return to reset values.
  - Required: the same stable `io_in` is re-delivered after 6 further edges.
- Instantiate with `STABLE_CYCLES = 1` and hold a constant input.
  - Required: commit 3 edges after sampling.
- Force 255 drops.
  - Required: `drop_count_o` saturates at 8'hFF.
